// File: rtl/neuron_mac.sv
// Eight-input binary neuron: one weighted add per cycle, then a threshold compare.
// Define NEURON_MAC_LEAK_EN to carry a leaky membrane potential across transactions.
module neuron_mac #(
  parameter int WIDTH_P = 3,
  parameter int ACC_W   = WIDTH_P + 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [7:0]         in_vec_i,
  input  logic [WIDTH_P-1:0] weight_0,
  input  logic [WIDTH_P-1:0] weight_1,
  input  logic [WIDTH_P-1:0] weight_2,
  input  logic [WIDTH_P-1:0] weight_3,
  input  logic [WIDTH_P-1:0] weight_4,
  input  logic [WIDTH_P-1:0] weight_5,
  input  logic [WIDTH_P-1:0] weight_6,
  input  logic [WIDTH_P-1:0] weight_7,
  input  logic [ACC_W-1:0]   threshold_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [ACC_W-1:0]   sum_o,
  output logic               fire_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         vec_q;
  logic [WIDTH_P-1:0] w_q [8];
  logic [ACC_W-1:0]   thr_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_load;
  logic [ACC_W-1:0]   addend;
  logic [2:0]         idx_q;
  logic               accept;
  logic               fire_w;

  assign accept = valid_i && (state_q == IDLE);
  assign fire_w = (acc_q >= thr_q);

`ifdef NEURON_MAC_LEAK_EN
  logic [ACC_W-1:0] retained_q;
  logic             handshake;

  assign handshake = (state_q == DONE) && ready_i;
  assign acc_load  = retained_q >> 1;

  // A fired neuron goes refractory; otherwise its potential carries over.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retained_q <= '0;
    end else if (handshake) begin
      retained_q <= fire_w ? '0 : acc_q;
    end
  end
`else
  assign acc_load = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = ACCUM;
      ACCUM:   if (idx_q == 3'd7) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addend = '0;
    if (vec_q[idx_q]) addend = ACC_W'(w_q[idx_q]);
  end

  // Operands are captured on accept so later input changes cannot leak in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vec_q <= '0;
      thr_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      for (int k = 0; k < 8; k++) w_q[k] <= '0;
    end else if (accept) begin
      vec_q  <= in_vec_i;
      thr_q  <= threshold_i;
      acc_q  <= acc_load;
      idx_q  <= '0;
      w_q[0] <= weight_0;
      w_q[1] <= weight_1;
      w_q[2] <= weight_2;
      w_q[3] <= weight_3;
      w_q[4] <= weight_4;
      w_q[5] <= weight_5;
      w_q[6] <= weight_6;
      w_q[7] <= weight_7;
    end else if (state_q == ACCUM) begin
      acc_q <= acc_q + addend;
      idx_q <= idx_q + 3'd1;
    end
  end

  assign ready_o = !rst_i && (state_q == IDLE);
  assign valid_o = !rst_i && (state_q == DONE);
  assign sum_o   = valid_o ? acc_q : '0;
  assign fire_o  = valid_o && fire_w;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: transaction-level model plus directed literal cases.
module tb_neuron_mac;

  localparam int WIDTH_P = 3;
  localparam int ACC_W   = WIDTH_P + 4;

`ifdef NEURON_MAC_LEAK_EN
  localparam bit LEAK = 1'b1;
`else
  localparam bit LEAK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_i = 1'b1;
  logic               valid_i = 1'b0;
  logic               ready_i = 1'b1;
  logic [7:0]         in_vec = '0;
  logic [WIDTH_P-1:0] w [8];
  logic [ACC_W-1:0]   thr = '0;
  logic               ready_o;
  logic               valid_o;
  logic [ACC_W-1:0]   sum_o;
  logic               fire_o;

  int checks = 0;
  int errors = 0;

  neuron_mac #(.WIDTH_P(WIDTH_P)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .in_vec_i(in_vec),
    .weight_0(w[0]), .weight_1(w[1]), .weight_2(w[2]), .weight_3(w[3]),
    .weight_4(w[4]), .weight_5(w[5]), .weight_6(w[6]), .weight_7(w[7]),
    .threshold_i(thr), .valid_o(valid_o), .ready_i(ready_i),
    .sum_o(sum_o), .fire_o(fire_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 computing, 2 result offered.
  int m_phase = 0;
  int m_cnt = 0;
  int m_sum = 0;
  int m_ret = 0;
  bit m_fire = 1'b0;

  function automatic int modelSum(input int base);
    int s = base;
    for (int k = 0; k < 8; k++) if (in_vec[k]) s += int'(w[k]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      m_phase = 0;
      m_ret = 0;
    end else begin
      case (m_phase)
        0: if (valid_i) begin
          m_sum = modelSum(LEAK ? m_ret / 2 : 0);
          m_fire = (m_sum >= int'(thr));
          m_cnt = 8;
          m_phase = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_phase = 2;
        end
        default: if (ready_i) begin
          m_ret = m_fire ? 0 : m_sum;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_i) begin
      checkOutput("rst_ready", ready_o, 0);
      checkOutput("rst_valid", valid_o, 0);
      checkOutput("rst_sum", sum_o, 0);
      checkOutput("rst_fire", fire_o, 0);
    end else begin
      checkOutput("mdl_ready", ready_o, m_phase == 0);
      checkOutput("mdl_valid", valid_o, m_phase == 2);
      if (m_phase == 2) begin
        checkOutput("mdl_sum", sum_o, m_sum);
        checkOutput("mdl_fire", fire_o, m_fire);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] vec, input int w0, input int wfill, input int t);
    in_vec = vec;
    w[0] = WIDTH_P'(w0);
    for (int k = 1; k < 8; k++) w[k] = WIDTH_P'(wfill);
    thr = ACC_W'(t);
  endtask

  task automatic runTxn(input logic [7:0] vec, input int w0, input int wfill, input int t,
                        input bit scramble, input int hold, input int exp_sum,
                        input bit exp_fire, input string tag);
    @(posedge clk); #1;
    applyStimulus(vec, w0, wfill, t);
    valid_i = 1'b1;
    ready_i = (hold == 0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (scramble) begin
        for (int k = 0; k < 8; k++) w[k] = WIDTH_P'($urandom);
        in_vec = 8'($urandom);
        thr = ACC_W'($urandom);
      end
      @(negedge clk);
      if (c == 8) checkOutput({tag, "_early_valid"}, valid_o, 0);
      if (c == 9) begin
        checkOutput({tag, "_valid"}, valid_o, 1);
        checkOutput({tag, "_sum"}, sum_o, exp_sum);
        checkOutput({tag, "_fire"}, fire_o, exp_fire);
      end else begin
        @(posedge clk); #1;
      end
    end
    for (int h = 1; h <= hold; h++) begin
      @(posedge clk); #1;
      valid_i = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, valid_o, 1);
      checkOutput({tag, "_hold_sum"}, sum_o, exp_sum);
      checkOutput({tag, "_hold_fire"}, fire_o, exp_fire);
      checkOutput({tag, "_hold_ready"}, ready_o, 0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      ready_i = 1'b1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, "_idle_ready"}, ready_o, 1);
    checkOutput({tag, "_idle_valid"}, valid_o, 0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) w[k] = '0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", ready_o, 1);
    checkOutput("post_rst_sum", sum_o, 0);

    runTxn(8'hFF, 7, 7, 56, 1'b0, 0, 56, 1'b1, "full");

    // Abort in the fourth accumulate cycle.
    @(posedge clk); #1;
    applyStimulus(8'hFF, 7, 7, 10);
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", ready_o, 1);
    checkOutput("abort_valid", valid_o, 0);
    checkOutput("abort_sum", sum_o, 0);
    repeat (12) begin
      @(negedge clk);
      checkOutput("abort_no_result", valid_o, 0);
    end

    runTxn(8'h01, 5, 3, 6, 1'b1, 0, 5, 1'b0, "mask");
    runTxn(8'h01, 5, 2, 6, 1'b0, 0, LEAK ? 7 : 5, LEAK, "leak2");
    runTxn(8'hA5, 3, 6, 21, 1'b0, 5, 21, 1'b1, "bp");

    for (int i = 0; i < 4; i++) begin
      int n;
      @(posedge clk); #1;
      in_vec = 8'($urandom);
      for (int k = 0; k < 8; k++) w[k] = WIDTH_P'($urandom);
      thr = ACC_W'($urandom_range(0, 60));
      valid_i = 1'b1;
      ready_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (valid_o !== 1'b1 && n < 20);
      if (valid_o !== 1'b1) checkOutput("rand_timeout", valid_o, 1);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter WIDTH_P, default 3: width of each weight.
REQ-002 SHALL have parameter ACC_W, fixed at WIDTH_P+4: accumulator, sum and threshold width.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port valid_i, input, 1: input transaction offered.
REQ-006 SHALL have port ready_o, output, 1: block can accept an input transaction.
REQ-007 SHALL have port in_vec_i, input, 8: binary features; bit k pairs with weight_k.
REQ-008 SHALL have ports weight_0..weight_7, input, WIDTH_P each: unsigned weights from the weight generator.
REQ-009 SHALL have port threshold_i, input, ACC_W: unsigned firing threshold.
REQ-010 SHALL have port valid_o, output, 1: result available.
REQ-011 SHALL have port ready_i, input, 1: downstream accepts the result.
REQ-012 SHALL have port sum_o, output, ACC_W: weighted sum.
REQ-013 SHALL have port fire_o, output, 1: neuron fired.

Function
REQ-014 SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-015 SHALL drive ready_o=1 only in IDLE and valid_o=1 only in DONE.
REQ-016 Accept SHALL occur when valid_i & ready_o are high; on accept, SHALL snapshot in_vec_i, weight_0..7 and threshold_i, set index to 0, load accumulator per REQ-026, and go to ACCUM.
REQ-017 Weight or input changes after the accept cycle SHALL NOT affect the result.
REQ-018 In ACCUM, each cycle SHALL add snapshot weight[index] to the accumulator if in_vec[index]=1, otherwise add 0, then increment index.
REQ-019 After index 7 is processed, SHALL go to DONE; for accept in cycle 0, valid_o SHALL be high in cycle 9.
REQ-020 In DONE, sum_o SHALL equal the accumulator and fire_o SHALL equal (accumulator >= threshold snapshot).
REQ-021 sum_o and fire_o SHALL be held stable while valid_o=1.
REQ-022 In DONE with ready_i=1, SHALL go to IDLE the next cycle, with no IDLE bypass; back-to-back period is 10 cycles minimum.
REQ-023 With ready_i=0, SHALL remain in DONE indefinitely.
REQ-024 valid_i SHALL be ignored outside IDLE.
REQ-025 Arithmetic SHALL be unsigned; ACC_W guarantees no overflow (max 2*8*(2^WIDTH_P-1) < 2^ACC_W), so no wrap or saturation logic is required.
REQ-026 Accumulator load on accept: cleared to 0, except as modified by REQ-033.

Reset
REQ-027 On rst_i=1 at a clock edge, SHALL set state to IDLE, accumulator to 0, index to 0 and all snapshots to 0.
REQ-028 While rst_i=1, ready_o, valid_o, fire_o and sum_o SHALL be 0; after reset, ready_o=1 and sum_o=0.
REQ-029 Reset SHALL take priority over any handshake in the same cycle.
REQ-030 Reset in ACCUM or DONE SHALL abort the transaction without producing a result.

Configuration
REQ-031 SHALL recognise the macro NEURON_MAC_LEAK_EN.
REQ-032 Without NEURON_MAC_LEAK_EN, the accumulator SHALL clear to 0 on every accept.
REQ-033 With NEURON_MAC_LEAK_EN, on accept the accumulator SHALL load retained_acc >> 1 (leaky membrane).
REQ-034 With NEURON_MAC_LEAK_EN, retained_acc SHALL be set on the result handshake to 0 if fire_o=1 (refractory clear), otherwise to sum_o.
REQ-035 With NEURON_MAC_LEAK_EN, reset SHALL clear retained_acc.

Verification (WIDTH_P=3)
REQ-036 Full sum: all weights 7, in_vec 8'hFF, threshold 56, ready_i=1 -> valid_o in cycle 9, sum_o=56, fire_o=1.
REQ-037 Masking plus snapshot: in_vec 8'h01, weight_0=5, threshold 6, weights changed every cycle after accept -> sum_o=5, fire_o=0.
REQ-038 Backpressure: ready_i=0 for 5 cycles in DONE -> valid_o, sum_o and fire_o held, ready_o=0, valid_i ignored; ready_i=1 -> IDLE next cycle.
REQ-039 Reset mid-operation: rst_i pulsed in the 4th ACCUM cycle -> next cycle IDLE, ready_o=1, valid_o=0, sum_o=0; no result is emitted.
REQ-040 Leak: two transactions, each in_vec 8'h01, weight_0=5, threshold 6 -> second sum_o=7, fire_o=1 with NEURON_MAC_LEAK_EN; second sum_o=5, fire_o=0 without it.
